// File: rtl/ram_bus_pkg.sv
// Shared types for the RAM bus initiator: FSM state encoding, default widths
// and the {cs,we,oe} pin tuple each state presents to the RAM.
package ram_bus_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 14;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    typedef struct packed {
        logic cs;
        logic we;
        logic oe;
    } pins_t;

    // RD and CAP present identical pins; the RAM only drives once its read
    // register has been loaded at the edge leaving RD.
    function automatic pins_t state_pins(input state_e s);
        pins_t p;
        case (s)
            ST_WR:   p = '{cs: 1'b1, we: 1'b1, oe: 1'b0};
            ST_RD:   p = '{cs: 1'b1, we: 1'b0, oe: 1'b1};
            ST_CAP:  p = '{cs: 1'b1, we: 1'b0, oe: 1'b1};
            default: p = '{cs: 1'b0, we: 1'b0, oe: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ram_data_iobuf.sv
// Tristate driver for the RAM data bus; the pad is always readable on din.
module ram_data_iobuf #(
    parameter int WIDTH = 16
) (
    input  logic             drive_en,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] pad
);

    assign pad = drive_en ? dout : {WIDTH{1'bz}};
    assign din = pad;

endmodule

// File: rtl/ram_bus_master.sv
// Request/response front end for a single-port synchronous RAM: sequences
// cs/we/oe, owns the data bus only while writing, and returns read data.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] bus_din;
    logic                  drive_en;
    pins_t                 pins;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_write ? ST_WR : ST_RD;
                end
            end
            ST_WR:  state_d = ST_IDLE;
            ST_RD:  state_d = ST_CAP;
            ST_CAP: begin
                rdata_d = bus_din;
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // WR is only ever entered from IDLE (cs=0), so the RAM has always
    // released the bus for at least one cycle before we drive it.
    assign drive_en  = (state_q == ST_WR);
    assign pins      = state_pins(state_q);
    assign ram_cs    = pins.cs;
    assign ram_we    = pins.we;
    assign ram_oe    = pins.oe;
    assign ram_addr  = addr_q;
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_rdata = rdata_q;

    ram_data_iobuf #(
        .WIDTH(DATA_WIDTH)
    ) u_iobuf (
        .drive_en(drive_en),
        .dout    (wdata_q),
        .din     (bus_din),
        .pad     (ram_data)
    );

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural synchronous RAM.
module tb_ram_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [13:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [13:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_cs, ram_we, ram_oe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_bus_master #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    // Behavioural RAM following the pin contract
    logic [15:0] mem [0:16383];
    logic [15:0] ram_rd_reg = 16'h0000;
    logic        ram_drive;
    assign ram_drive = ram_cs && ram_oe && !ram_we;
    assign ram_data  = ram_drive ? ram_rd_reg : 16'hzzzz;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) ram_rd_reg <= mem[ram_addr];
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    end

    task automatic wait_accept();
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] d,
                            output logic [2:0] pins_wr, output logic [15:0] bus_wr,
                            output logic [13:0] addr_wr, output logic rdy_after);
        req_addr = a; req_wdata = d; req_write = 1'b1; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        pins_wr = {ram_cs, ram_we, ram_oe};
        bus_wr  = ram_data;
        addr_wr = ram_addr;
        @(posedge clk); #1;
        rdy_after = req_ready;
    endtask

    // Returns in the first cycle rsp_valid is seen; lat counts edges since acceptance
    task automatic do_read(input logic [13:0] a, output logic [15:0] d, output int lat);
        req_addr = a; req_write = 1'b0; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if ({req_ready, rsp_valid, busy, ram_cs, ram_we, ram_oe} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {req_ready, rsp_valid, busy, ram_cs, ram_we, ram_oe});
        end
        n_checks++;
        if (rsp_rdata !== 16'h0000 || ram_addr !== 14'h0000) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h addr %h expected 0000 0000", rsp_rdata, ram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        logic [2:0]  p;
        logic [15:0] b, d;
        logic [13:0] wa;
        logic        r;
        int          lat;
        do_write(14'h0FFC, 16'hA5A5, p, b, wa, r);
        n_checks++;
        if (p !== 3'b110) begin n_fail++; $display("FAIL wr_pins: got %b expected 110", p); end
        n_checks++;
        if (b !== 16'hA5A5 || wa !== 14'h0FFC) begin
            n_fail++; $display("FAIL wr_bus: data %h addr %h expected a5a5 0ffc", b, wa);
        end
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after: got %b expected 1", r); end
        do_read(14'h0FFC, d, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        n_checks++;
        if (d !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data: got %h expected a5a5", d); end
        @(posedge clk); #1;
        $display("test_write_read: wrote a5a5 @0ffc, read %h latency %0d", d, lat);
    endtask

    task automatic test_boundary();
        logic [2:0]  p;
        logic [15:0] b, d0, d1;
        logic [13:0] wa;
        logic        r;
        int          lat;
        do_write(14'h0000, 16'h1234, p, b, wa, r);
        do_write(14'h3FFF, 16'hBEEF, p, b, wa, r);
        n_checks++;
        if (wa !== 14'h3FFF) begin n_fail++; $display("FAIL bnd_addr: got %h expected 3fff", wa); end
        do_read(14'h0000, d0, lat);
        @(posedge clk); #1;
        do_read(14'h3FFF, d1, lat);
        @(posedge clk); #1;
        n_checks++;
        if (d0 !== 16'h1234) begin n_fail++; $display("FAIL bnd_low: got %h expected 1234", d0); end
        n_checks++;
        if (d1 !== 16'hBEEF) begin n_fail++; $display("FAIL bnd_high: got %h expected beef", d1); end
        $display("test_boundary: @0000=%h @3fff=%h", d0, d1);
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        int          lat;
        rsp_ready = 1'b0;
        do_read(14'h0FFC, d, lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, req_ready, busy} !== 3'b101 || rsp_rdata !== 16'hA5A5) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid/ready/busy %b data %h expected 101 a5a5",
                         i, {rsp_valid, req_ready, busy}, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_release: valid/ready/busy %b expected 010", {rsp_valid, req_ready, busy});
        end
        $display("test_backpressure: held 5 cycles, released");
    endtask

    task automatic test_back_to_back();
        logic        prev_cs = 1'b0;
        logic        seen_wr = 1'b0;
        logic [15:0] d;
        int          lat;
        req_addr = 14'h0FFC; req_write = 1'b0; req_valid = 1'b1;
        wait_accept();
        req_addr = 14'h0200; req_wdata = 16'h5A5A; req_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ram_oe) begin
                n_checks++;
                if (dut.drive_en !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_contention: cycle %0d drive_en %b expected 0", i, dut.drive_en);
                end
            end
            if (ram_cs && ram_we && !seen_wr) begin
                seen_wr = 1'b1;
                req_valid = 1'b0;
                n_checks++;
                if (prev_cs !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_turnaround: prev cs %b expected 0", prev_cs);
                end
                n_checks++;
                if (ram_data !== 16'h5A5A) begin
                    n_fail++; $display("FAIL b2b_wdata: got %h expected 5a5a", ram_data);
                end
            end
            prev_cs = ram_cs;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (seen_wr !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_seen: got %b expected 1", seen_wr); end
        do_read(14'h0200, d, lat);
        @(posedge clk); #1;
        n_checks++;
        if (d !== 16'h5A5A) begin n_fail++; $display("FAIL b2b_readback: got %h expected 5a5a", d); end
        $display("test_back_to_back: readback %h", d);
    endtask

    task automatic test_reset_in_wr();
        logic [2:0]  p;
        logic [15:0] b, d;
        logic [13:0] wa;
        logic        r;
        int          lat;
        do_write(14'h0100, 16'h1111, p, b, wa, r);
        req_addr = 14'h0100; req_wdata = 16'h2222; req_write = 1'b1; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        n_checks++;
        if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rwr_in_wr: we %b expected 1", ram_we); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy, ram_cs, ram_we, ram_oe} !== 6'b100000 ||
            ram_addr !== 14'h0000 || dut.drive_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rwr_async: ctrl %b addr %h drive %b expected 100000 0000 0",
                     {req_ready, rsp_valid, busy, ram_cs, ram_we, ram_oe}, ram_addr, dut.drive_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(14'h0100, d, lat);
        @(posedge clk); #1;
        n_checks++;
        if (d !== 16'h1111) begin n_fail++; $display("FAIL rwr_dropped: got %h expected 1111", d); end
        $display("test_reset_in_wr: readback %h", d);
    endtask

    task automatic test_reset_in_cap();
        logic        any_valid = 1'b0;
        logic [15:0] d;
        int          lat;
        req_addr = 14'h3FFF; req_write = 1'b0; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dut.state_q !== ram_bus_pkg::ST_CAP) begin
            n_fail++; $display("FAIL rcap_state: got %0d expected %0d", dut.state_q, ram_bus_pkg::ST_CAP);
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) any_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) any_valid = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (any_valid !== 1'b0) begin n_fail++; $display("FAIL rcap_no_rsp: got %b expected 0", any_valid); end
        n_checks++;
        if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rcap_rdata: got %h expected 0000", rsp_rdata); end
        do_read(14'h0000, d, lat);
        @(posedge clk); #1;
        n_checks++;
        if (lat !== 3 || d !== 16'h1234) begin
            n_fail++; $display("FAIL rcap_next_read: lat %0d data %h expected 3 1234", lat, d);
        end
        $display("test_reset_in_cap: next read %h latency %0d", d, lat);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wr();
        test_reset_in_cap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Bus initiator for the 16-bit single-port synchronous RAM.
- Accepts read/write requests on a valid/ready request channel and sequences chip_select, write_enable and output_enable on the RAM pins.
- Drives and releases the bidirectional data bus with guaranteed turnaround.
- Returns read data on a valid/ready response channel; sits between the CPU datapath and the RAM instance.

Parameters:
ADDR_WIDTH, 14, RAM word address width
DATA_WIDTH, 16, RAM word width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts read data
rsp_rdata  output  DATA_WIDTH  read data
busy  output  1  state != IDLE
ram_addr  output  ADDR_WIDTH  RAM address
ram_data  inout  DATA_WIDTH  RAM bidirectional data bus
ram_cs  output  1  RAM chip_select
ram_we  output  1  RAM write_enable
ram_oe  output  1  RAM output_enable

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is asynchronous and active-high.
- RAM contract:
  - Edge with cs=1, we=1: mem[addr] <= data.
  - Edge with cs=1, we=0: internal read register <= mem[addr].
  - RAM drives data only while cs=1, oe=1, we=0.
- FSM states: IDLE, WR, RD, CAP, RSP. Pin outputs are a Moore decode of the state register plus registered addr/wdata.
- IDLE:
  - req_ready=1; cs=we=oe=0; bus released (Z).
  - On an edge with req_valid&req_ready: latch addr and wdata; go to WR if req_write, else RD.
- WR:
  - cs=1, we=1, oe=0; ram_addr=latched addr; controller drives ram_data=latched wdata.
  - Next state IDLE. The RAM writes at the edge leaving WR.
- RD:
  - cs=1, we=0, oe=1; ram_addr=latched addr; bus released. Next state CAP.
- CAP:
  - Same pin values as RD; the RAM drives the bus.
  - At the leaving edge, rsp_rdata <= ram_data. Next state RSP.
- RSP:
  - cs=we=oe=0; rsp_valid=1; rsp_rdata held stable.
  - Leaves to IDLE on an edge with rsp_ready=1. rsp_ready may already be high on entry.
- Controller drive enable is asserted only in WR; it is never active in RD/CAP. Because WR is always entered from IDLE, with cs=0 there, turnaround is guaranteed.
- Latency, with acceptance edge E0:
  - Write: RAM write at E0+1; req_ready high again in the cycle after E0+1. Back-to-back write throughput is 1 per 2 cycles.
  - Read: rsp_valid asserted in the cycle after E0+2 (3 cycles). Minimum read occupancy is 4 cycles.
- Requests arriving while busy are not accepted; req_ready=0. The requester holds them per valid/ready rules.
- rsp_valid never deasserts without rsp_ready.
- Addresses 0 through 2^ADDR_WIDTH-1 are all valid; there is no wrap logic, and the address is passed through unchanged.
- Reset, asynchronous at any time including mid-WR or mid-RD:
  - State returns to IDLE; drive enable is cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, ram_addr=0, cs=we=oe=0, bus Z.
  - An in-flight write whose edge has not occurred is dropped; an in-flight read produces no response.

Decomposition:
- Package ram_bus_pkg holds: the state enum (IDLE, WR, RD, CAP, RSP), default ADDR_WIDTH/DATA_WIDTH localparams, and the encoded pin tuple {cs,we,oe} per state.
- One sub-module, ram_data_iobuf: a parameterised tristate driver. Inputs are drive_en and dout; outputs are din and the inout pad. All FSM logic stays in ram_bus_master.

Test Plan:
- Write 0xA5A5 to 0x0FFC, then read 0x0FFC with rsp_ready=1:
  - One WR cycle with cs=1, we=1, oe=0.
  - rsp_valid rises 3 cycles after read acceptance with rsp_rdata=0xA5A5.
- Boundary addresses: write 0x1234 to 0x0000 and 0xBEEF to 0x3FFF, then read both back. Expect exact values with no aliasing.
- Backpressure: issue a read and hold rsp_ready=0 for 5 cycles.
  - rsp_valid stays 1 with stable data; req_ready=0 and busy=1 throughout.
  - On the release edge, rsp_valid drops and req_ready returns to 1.
- Read immediately followed by write, with req_valid held high:
  - ram_data never shows X or contention.
  - At least one IDLE cycle with cs=0 separates CAP from WR.
- Assert rst in the WR cycle before its edge:
  - All outputs take reset values immediately (asynchronous) and ram_data goes to Z.
  - A subsequent read of that address returns the prior contents.
- Assert rst in CAP: rsp_valid never asserts; the next read request is accepted normally.
